// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and helpers for the SPI register-file peripheral
package spi_pkg;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    WDATA,
    RDATA
  } spi_state_e;

  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - multi-stage synchroniser with edge detection for one async SPI pin
module spi_pin_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// rtl/spi_regfile_peripheral.sv - SPI mode-0 peripheral with register file, read-back and frame checks
module spi_regfile_peripheral
  import spi_pkg::*;
#(
  parameter int NUM_REGS    = 5,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       copi,
  input  logic                       sclk,
  input  logic                       ncs,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_pulse,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int CNT_W   = 6;
  localparam logic [CNT_W-1:0]  CNT_HDR    = CNT_W'(1 + ADDR_W);
  localparam logic [CNT_W-1:0]  CNT_FRAME  = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(FRAME_W + 1);
  localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);

  logic copi_lvl, copi_rise, copi_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ncs_lvl, ncs_rise, ncs_fall;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .pin_i(copi),
    .level_o(copi_lvl), .rise_o(copi_rise), .fall_o(copi_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .pin_i(sclk),
    .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .pin_i(ncs),
    .level_o(ncs_lvl), .rise_o(ncs_rise), .fall_o(ncs_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{copi_rise, copi_fall, sclk_lvl};

  spi_state_e                       state_q, state_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [FRAME_W-1:0]               shift_q, shift_d;
  logic [DATA_W-1:0]                tx_q, tx_d;
  logic                             cipo_q, cipo_d;
  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_q, regs_d;
  logic                             wr_pulse_q, wr_pulse_d;
  logic [ADDR_W-1:0]                wr_addr_q, wr_addr_d;
  logic                             err_q, err_d;

  logic [FRAME_W-1:0] shift_nx;
  logic [CNT_W-1:0]   cnt_inc;
  logic               hdr_rw;
  logic [ADDR_W-1:0]  hdr_addr;
  logic [DATA_W-1:0]  hdr_rd_data;
  logic               f_rw;
  logic [ADDR_W-1:0]  f_addr;
  logic [DATA_W-1:0]  f_data;
  logic               frame_active;
  logic               len_ok;

  assign shift_nx     = {shift_q[FRAME_W-2:0], copi_lvl};
  assign cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign hdr_rw       = shift_nx[ADDR_W];
  assign hdr_addr     = shift_nx[ADDR_W-1:0];
  assign f_rw         = shift_q[FRAME_W-1];
  assign f_addr       = shift_q[DATA_W +: ADDR_W];
  assign f_data       = shift_q[DATA_W-1:0];
  assign frame_active = (state_q != IDLE) && !ncs_lvl;
  assign len_ok       = (cnt_q == CNT_FRAME);

  // Read-back mux; out-of-range addresses read as zero.
  always_comb begin
    hdr_rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (hdr_addr == ADDR_W'(k)) hdr_rd_data = regs_q[k];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    cipo_d     = cipo_q;
    regs_d     = regs_q;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    err_d      = 1'b0;

    if (ncs_rise) begin
      state_d = IDLE;
      cipo_d  = 1'b0;
      tx_d    = '0;
      // An empty select (no bits clocked) is silently ignored.
      if (cnt_q != '0) begin
        if (len_ok && f_rw == RW_WRITE && f_addr < NUM_REGS_A) begin
          for (int k = 0; k < NUM_REGS; k++) begin
            if (f_addr == ADDR_W'(k)) regs_d[k] = f_data;
          end
          wr_pulse_d = 1'b1;
          wr_addr_d  = f_addr;
        end else if (!(len_ok && f_rw == RW_READ)) begin
          err_d = 1'b1;
        end
      end
    end else if (ncs_fall) begin
      state_d = HDR;
      cnt_d   = '0;
      shift_d = '0;
      tx_d    = '0;
      cipo_d  = 1'b0;
    end else if (frame_active) begin
      if (sclk_rise) begin
        shift_d = shift_nx;
        cnt_d   = cnt_inc;
        if (state_q == HDR && cnt_inc == CNT_HDR) begin
          state_d = (hdr_rw == RW_WRITE) ? WDATA : RDATA;
          tx_d    = hdr_rd_data;
        end
      end
      // Zero-fill means cipo idles low once all data bits are out.
      if (sclk_fall && state_q == RDATA) begin
        cipo_d = tx_q[DATA_W-1];
        tx_d   = {tx_q[DATA_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      cipo_q     <= 1'b0;
      regs_q     <= '0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      cipo_q     <= cipo_d;
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
      err_q      <= err_d;
    end
  end

  assign cipo_oe   = (state_q == RDATA) && !ncs_rise;
  assign cipo      = cipo_q & cipo_oe;
  assign regs_out  = regs_q;
  assign wr_pulse  = wr_pulse_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = err_q;

endmodule
